gift_share_refresh_stage: RTL and testbench

- Input stage directly upstream of the 3-share GIFT affine/quadratic S-box datapath.
- Accepts a 3-share nibble, remasks it with fresh randomness, and holds the refreshed shares in a 2-entry register buffer.
- Each share leaves through a flop with a valid/ready handshake, so glitches cannot combine input and random shares before the nonlinear layer.
- Unmasked value x1^x2^x3 is never computed anywhere in the block.

---
 rtl/gift_mask_pkg.sv | 30 +++
 rtl/gift_share_refresh_stage_if.sv | 36 +++
 rtl/share_reg_entry.sv | 39 +++
 rtl/gift_share_refresh_stage.sv | 92 +++++++++
 tb/tb_gift_share_refresh_stage.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gift_mask_pkg.sv
`default_nettype none
// ============================================================================
// Module : gift_mask_pkg
// Brief  : Share types and the 3-share refresh function for masked GIFT.
// Rev    : 1.0
// ============================================================================
package gift_mask_pkg;

    localparam int SHARE_W    = 4;
    localparam int NUM_SHARES = 3;

    typedef struct packed {
        logic [SHARE_W-1:0] s1;
        logic [SHARE_W-1:0] s2;
        logic [SHARE_W-1:0] s3;
    } share3_t;

    // Each output share only ever mixes its own input share with randomness.
    function automatic share3_t refresh3(input share3_t x,
                                         input logic [SHARE_W-1:0] r1,
                                         input logic [SHARE_W-1:0] r2);
        share3_t y;
        y.s1 = x.s1 ^ r1;
        y.s2 = x.s2 ^ r2;
        y.s3 = x.s3 ^ r1 ^ r2;
        return y;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gift_share_refresh_stage_if.sv
`default_nettype none
// ============================================================================
// Module : gift_share_refresh_stage_if
// Brief  : Input, randomness and output handshakes of the share refresh stage.
// Rev    : 1.0
// ============================================================================
interface gift_share_refresh_stage_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   x1;
    logic [WIDTH-1:0]   x2;
    logic [WIDTH-1:0]   x3;
    logic               rnd_valid;
    logic               rnd_ready;
    logic [2*WIDTH-1:0] rnd;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   y1;
    logic [WIDTH-1:0]   y2;
    logic [WIDTH-1:0]   y3;
    logic [CNT_W-1:0]   refresh_cnt;

    modport master (
        output in_valid, x1, x2, x3, rnd_valid, rnd, out_ready,
        input  in_ready, rnd_ready, out_valid, y1, y2, y3, refresh_cnt
    );

    modport slave (
        input  in_valid, x1, x2, x3, rnd_valid, rnd, out_ready,
        output in_ready, rnd_ready, out_valid, y1, y2, y3, refresh_cnt
    );
endinterface
`default_nettype wire

// File: rtl/share_reg_entry.sv
`default_nettype none
// ============================================================================
// Module : share_reg_entry
// Brief  : One registered 3-share word plus valid bit, with load and clear.
// Rev    : 1.0
// ============================================================================
module share_reg_entry
    import gift_mask_pkg::*;
(
    input  wire logic    clk,
    input  wire logic    rst,
    input  wire logic    load,
    input  wire logic    clear,
    input  wire share3_t d,
    output share3_t      q,
    output logic         v
);

    share3_t r_q;
    logic    r_v;

    // Load wins over clear so a shift-in and a pop in the same cycle keep data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
            r_v <= 1'b0;
        end else if (load) begin
            r_q <= d;
            r_v <= 1'b1;
        end else if (clear) begin
            r_v <= 1'b0;
        end
    end

    assign q = r_q;
    assign v = r_v;

endmodule
`default_nettype wire

// File: rtl/gift_share_refresh_stage.sv
`default_nettype none
// ============================================================================
// Module : gift_share_refresh_stage
// Brief  : Remasks a 3-share nibble and buffers it in a 2-entry register FIFO.
// Rev    : 1.0
// ============================================================================
module gift_share_refresh_stage
    import gift_mask_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    gift_share_refresh_stage_if.slave   bus
);

    share3_t            w_x;
    share3_t            w_refreshed;
    share3_t            w_e0_d;
    share3_t            w_e0_q;
    share3_t            w_e1_q;
    logic [WIDTH-1:0]   w_r1;
    logic [WIDTH-1:0]   w_r2;
    logic               w_e0_v;
    logic               w_e1_v;
    logic               w_in_ready;
    logic               w_fire;
    logic               w_pop;
    logic               w_e0_load;
    logic               w_e0_clear;
    logic               w_e1_load;
    logic [CNT_W-1:0]   r_cnt;

    assign w_r1 = bus.rnd[WIDTH-1:0];
    assign w_r2 = bus.rnd[2*WIDTH-1:WIDTH];

    assign w_x.s1 = bus.x1;
    assign w_x.s2 = bus.x2;
    assign w_x.s3 = bus.x3;

    assign w_refreshed = refresh3(w_x, w_r1, w_r2);

    // Ready depends only on entry flops, never on out_ready.
    assign w_in_ready = !(w_e0_v && w_e1_v);
    assign w_fire     = bus.in_valid && bus.rnd_valid && w_in_ready;
    assign w_pop      = w_e0_v && bus.out_ready;

    // Fire and a shift from e1 are exclusive: e1 valid with a pop implies full.
    assign w_e0_load  = (w_pop && w_e1_v) || (w_fire && (!w_e0_v || w_pop));
    assign w_e0_clear = w_pop;
    assign w_e1_load  = w_fire && w_e0_v && !w_pop;
    assign w_e0_d     = (w_pop && w_e1_v) ? w_e1_q : w_refreshed;

    share_reg_entry u_e0 (
        .clk   (clk),
        .rst   (rst),
        .load  (w_e0_load),
        .clear (w_e0_clear),
        .d     (w_e0_d),
        .q     (w_e0_q),
        .v     (w_e0_v)
    );

    share_reg_entry u_e1 (
        .clk   (clk),
        .rst   (rst),
        .load  (w_e1_load),
        .clear (w_pop),
        .d     (w_refreshed),
        .q     (w_e1_q),
        .v     (w_e1_v)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_fire && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.rnd_ready   = bus.in_valid && w_in_ready;
    assign bus.out_valid   = w_e0_v;
    assign bus.y1          = w_e0_q.s1;
    assign bus.y2          = w_e0_q.s2;
    assign bus.y3          = w_e0_q.s3;
    assign bus.refresh_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_gift_share_refresh_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_gift_share_refresh_stage
// Brief  : Scoreboard bench for the share refresh stage with directed vectors.
// Rev    : 1.0
// ============================================================================
module tb_gift_share_refresh_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gift_share_refresh_stage_if #(.WIDTH(4), .CNT_W(16)) bus  ();
    gift_share_refresh_stage_if #(.WIDTH(4), .CNT_W(4))  bus4 ();

    gift_share_refresh_stage #(.WIDTH(4), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    gift_share_refresh_stage #(.WIDTH(4), .CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    typedef struct {
        logic [11:0] y;
        logic [3:0]  xr;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [11:0] stream_exp [8] = '{12'h123, 12'h032, 12'h301, 12'h210,
                                    12'h567, 12'h476, 12'h745, 12'h654};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected values only enter the queue once the handshake is certain to fire.
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [7:0] r, input logic [11:0] e);
        bit done;
        done = 1'b0;
        bus.in_valid  = 1'b1;
        bus.rnd_valid = 1'b1;
        bus.x1 = a;
        bus.x2 = b;
        bus.x3 = c;
        bus.rnd = r;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back('{y: e, xr: a ^ b ^ c});
                done = 1'b1;
            end
        end
        if (!done) check("send_timeout", {31'b0, done}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.rnd_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
    endtask

    task automatic drain();
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.out_valid) break;
        end
        check("drain_empty", sb.size(), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: actual=%0h required=none",
                         {bus.y1, bus.y2, bus.y3});
            end else begin
                m_e = sb.pop_front();
                check("y_shares", {20'b0, bus.y1, bus.y2, bus.y3}, {20'b0, m_e.y});
                check("share_xor", {28'b0, bus.y1 ^ bus.y2 ^ bus.y3}, {28'b0, m_e.xr});
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 0; bus.rnd_valid = 0; bus.out_ready = 0;
        bus.x1 = 0; bus.x2 = 0; bus.x3 = 0; bus.rnd = 0;
        bus4.in_valid = 0; bus4.rnd_valid = 0; bus4.out_ready = 0;
        bus4.x1 = 0; bus4.x2 = 0; bus4.x3 = 0; bus4.rnd = 0;
        do_reset();

        // Reset state
        @(negedge clk);
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_y", {20'b0, bus.y1, bus.y2, bus.y3}, 32'd0);
        check("rst_cnt", {16'b0, bus.refresh_cnt}, 32'd0);
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("rst_rnd_ready", {31'b0, bus.rnd_ready}, 32'd0);

        // Basic refresh with 1-cycle latency
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        send(4'h3, 4'h5, 4'h9, 8'hA6, 12'h5F5);
        idle();
        @(negedge clk);
        check("basic_latency", {31'b0, bus.out_valid}, 32'd1);
        check("basic_cnt", {16'b0, bus.refresh_cnt}, 32'd1);
        drain();

        // Randomness starvation
        bus.in_valid = 1'b1; bus.rnd_valid = 1'b0;
        bus.x1 = 4'h1; bus.x2 = 4'h2; bus.x3 = 4'h4;
        repeat (3) begin
            @(negedge clk);
            check("starve_rnd_ready", {31'b0, bus.rnd_ready}, 32'd1);
            check("starve_out_valid", {31'b0, bus.out_valid}, 32'd0);
            check("starve_cnt", {16'b0, bus.refresh_cnt}, 32'd1);
        end
        @(posedge clk); #1;
        send(4'h1, 4'h2, 4'h4, 8'h00, 12'h124);
        idle();
        @(negedge clk);
        check("starve_cnt_after", {16'b0, bus.refresh_cnt}, 32'd2);
        drain();

        // Backpressure and full
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send(4'h7, 4'h0, 4'hE, 8'h5C, 12'hB57);
        send(4'hF, 4'hF, 4'hF, 8'hFF, 12'h00F);
        bus.in_valid = 1'b1; bus.rnd_valid = 1'b1;
        bus.x1 = 4'hA; bus.x2 = 4'hB; bus.x3 = 4'hC; bus.rnd = 8'h12;
        repeat (4) begin
            @(negedge clk);
            check("full_in_ready", {31'b0, bus.in_ready}, 32'd0);
            check("full_head", {20'b0, bus.y1, bus.y2, bus.y3}, 32'hB57);
            check("full_cnt", {16'b0, bus.refresh_cnt}, 32'd4);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        send(4'hA, 4'hB, 4'hC, 8'h12, 12'h8AF);
        idle();
        drain();
        check("full_cnt_after", {16'b0, bus.refresh_cnt}, 32'd5);

        // Streaming with simultaneous fire and pop
        do_reset();
        bus.out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(4'(i), 4'(i), 4'(i), 8'h21, stream_exp[i]);
                idle();
            end
            begin
                int seen;
                seen = 0;
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    if (bus.out_valid) break;
                end
                if (bus.out_valid) seen = 1;
                repeat (7) begin
                    @(negedge clk);
                    if (bus.out_valid) seen++;
                end
                check("stream_no_bubble", seen, 32'd8);
            end
        join
        drain();
        check("stream_cnt", {16'b0, bus.refresh_cnt}, 32'd8);

        // Reset mid-operation
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send(4'h1, 4'h1, 4'h1, 8'h00, 12'h111);
        send(4'h2, 4'h2, 4'h2, 8'h00, 12'h222);
        idle();
        @(negedge clk);
        check("mid_full", {30'b0, bus.out_valid, bus.in_ready}, 32'd2);
        do_reset();
        @(negedge clk);
        check("mid_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("mid_y", {20'b0, bus.y1, bus.y2, bus.y3}, 32'd0);
        check("mid_cnt", {16'b0, bus.refresh_cnt}, 32'd0);
        check("mid_in_ready", {31'b0, bus.in_ready}, 32'd1);
        bus.out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("mid_no_emit", {31'b0, bus.out_valid}, 32'd0);
        end

        // Counter saturation on the narrow-counter instance
        do_reset();
        bus4.in_valid = 1'b1; bus4.rnd_valid = 1'b1; bus4.out_ready = 1'b1;
        bus4.x1 = 4'h6; bus4.x2 = 4'h9; bus4.x3 = 4'h3; bus4.rnd = 8'h5A;
        repeat (14) @(posedge clk);
        #1;
        check("sat_cnt_14", {28'b0, bus4.refresh_cnt}, 32'd14);
        @(negedge clk);
        check("sat_shares", {20'b0, bus4.y1, bus4.y2, bus4.y3}, 32'hCCC);
        repeat (3) @(posedge clk);
        #1;
        check("sat_cnt_17", {28'b0, bus4.refresh_cnt}, 32'd15);
        repeat (4) @(posedge clk);
        #1;
        check("sat_cnt_hold", {28'b0, bus4.refresh_cnt}, 32'd15);
        bus4.in_valid = 1'b0; bus4.rnd_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
